// File: rtl/avm_rom_reader_pkg.sv
// Shared types and constants for the Avalon-MM ROM block reader.
package avm_rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdr_state_t;

  localparam logic [3:0] AVM_BE_ALL = 4'hF;

  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 14;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/avm_rom_reader_if.sv
// Avalon-MM read-master bus between the reader and the interconnect.
interface avm_rom_reader_if
  import avm_rom_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avm_reader_fifo.sv
// Show-ahead return-data FIFO; head word is visible whenever the FIFO is non-empty.
module avm_reader_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
    if (reset_n) begin
      assert (!(push && count == CNT_W'(FIFO_DEPTH)));
      assert (!(pop && count == '0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);
  // Empty FIFO presents zero so the stream data is clean out of reset.
  assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/avm_rom_reader.sv
// Avalon-MM block reader: one command fetches consecutive words and streams them out in order.
module avm_rom_reader
  import avm_rom_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  avm_rom_reader_if.master  avm,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  rdr_state_t        state;
  logic [ADDR_W-1:0] address_q;
  logic              read_q;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  pop_cnt;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept;
  logic              rdv_ok;
  logic              pop;
  logic [CNT_W:0]    inflight;
  logic              credit;

  assign accept   = read_q && !avm.waitrequest;
  assign rdv_ok   = avm.readdatavalid && (outstanding != '0 || accept);
  assign pop      = src_valid && src_ready;
  // Count the read being accepted now so the next request never overruns the FIFO.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count} + {{CNT_W{1'b0}}, accept};
  assign credit   = inflight < DEPTH_L;

  assign avm.address    = address_q;
  assign avm.read       = read_q;
  assign avm.byteenable = AVM_BE_ALL;
  assign src_last       = src_valid && (pop_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      address_q   <= '0;
      read_q      <= 1'b0;
      remaining   <= '0;
      len_q       <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (avm.readdatavalid && !rdv_ok) err <= 1'b1;
      unique case ({accept, rdv_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (pop) pop_cnt <= pop_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            address_q <= cmd_addr;
            len_q     <= cmd_len;
            remaining <= cmd_len;
            pop_cnt   <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= ISSUE;
              read_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // A raised request is held until the slave takes it, credit or not.
          if (accept) begin
            address_q <= address_q + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              read_q <= 1'b0;
              state  <= DRAIN;
            end else begin
              read_q <= credit;
            end
          end else if (!read_q) begin
            read_q <= credit;
          end
        end
        DRAIN: begin
          if (pop && src_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  avm_reader_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rdv_ok),
    .push_data (avm.readdata),
    .pop       (pop),
    .data      (src_data),
    .valid     (src_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_avm_rom_reader.sv
// Directed bench for avm_rom_reader with a reactive 1-cycle-latency Avalon slave model.
module tb_avm_rom_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [13:0] cmd_addr = '0;
  logic [13:0] cmd_len = '0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready = 1'b1;
  logic        src_last;
  logic        busy;
  logic        done;
  logic        err;

  avm_rom_reader_if #(.ADDR_W(14), .DATA_W(32)) avm();

  avm_rom_reader #(
    .ADDR_W(14), .DATA_W(32), .LEN_W(14), .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .avm       (avm.master),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_last  (src_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model and stream sink state
  logic        rand_wait = 1'b0;
  logic        inject_rdv = 1'b0;
  logic        pend = 1'b0;
  logic [13:0] pend_addr = '0;
  logic        stall_prev = 1'b0;
  logic [13:0] prev_addr = '0;
  logic [31:0] got_data [$];
  logic        got_last [$];
  logic [13:0] acc_addrs [$];
  int          acc_total = 0;
  int          pop_total = 0;
  int          max_inflight = 0;
  int          run = 0;
  int          max_run = 0;
  int          last_pop_cyc = 0;

  initial begin
    avm.waitrequest   = 1'b0;
    avm.readdata      = '0;
    avm.readdatavalid = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
      stall_prev = 1'b0;
      avm.waitrequest = 1'b0;
      avm.readdatavalid = 1'b0;
      avm.readdata = '0;
      run = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_read_hold", 32'(avm.read), 32'h1);
        chk("stall_addr_hold", 32'(avm.address), 32'(prev_addr));
      end
      avm.readdatavalid = pend || inject_rdv;
      avm.readdata = pend ? pat(pend_addr) : 32'hDEADBEEF;
      avm.waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      pend = avm.read && !avm.waitrequest;
      if (pend) begin
        pend_addr = avm.address;
        acc_addrs.push_back(avm.address);
        acc_total++;
      end
      stall_prev = avm.read && avm.waitrequest;
      prev_addr = avm.address;
      if (src_valid && src_ready) begin
        got_data.push_back(src_data);
        got_last.push_back(src_last);
        pop_total++;
        last_pop_cyc = cyc;
      end
      if (acc_total - pop_total > max_inflight) max_inflight = acc_total - pop_total;
      run = avm.read ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end

  task automatic clear_capture();
    got_data.delete();
    got_last.delete();
    acc_addrs.delete();
    acc_total = 0;
    pop_total = 0;
    max_inflight = 0;
    max_run = 0;
  endtask

  task automatic send_cmd(input logic [13:0] a, input logic [13:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'h1);
    dcyc = cyc;
  endtask

  task automatic check_words(input logic [13:0] a0, input int len);
    logic [13:0] a;
    chk("word_count", 32'(got_data.size()), 32'(len));
    chk("read_count", 32'(acc_addrs.size()), 32'(len));
    for (int i = 0; i < len && i < got_data.size() && i < acc_addrs.size(); i++) begin
      a = a0 + 14'(i);
      chk($sformatf("rd_addr[%0d]", i), 32'(acc_addrs[i]), 32'(a));
      chk($sformatf("data[%0d]", i), got_data[i], pat(a));
      chk($sformatf("last[%0d]", i), 32'(got_last[i]), 32'(i == len - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, "_read"}, 32'(avm.read), 32'h0);
    chk({tag, "_address"}, 32'(avm.address), 32'h0);
    chk({tag, "_src_valid"}, 32'(src_valid), 32'h0);
    chk({tag, "_src_last"}, 32'(src_last), 32'h0);
    chk({tag, "_src_data"}, src_data, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int dcyc;
    int acc0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    chk("byteenable", 32'(avm.byteenable), 32'hF);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait burst, addr 0, len 16
    clear_capture();
    src_ready = 1'b1;
    send_cmd(14'h0000, 14'd16);
    chk("t1_read_cycle1", 32'(avm.read), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_cmd_ready_low", 32'(cmd_ready), 32'h0);
    wait_done(200, dcyc);
    chk("t1_done_latency", 32'(dcyc), 32'(last_pop_cyc + 1));
    chk("t1_cmd_ready_at_done", 32'(cmd_ready), 32'h0);
    check_words(14'h0000, 16);
    chk("t1_read_run", 32'(max_run), 32'd16);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_cmd_ready_back", 32'(cmd_ready), 32'h1);
    chk("t1_busy_low", 32'(busy), 32'h0);

    // Random waitrequest
    clear_capture();
    rand_wait = 1'b1;
    send_cmd(14'h0100, 14'd16);
    wait_done(600, dcyc);
    rand_wait = 1'b0;
    check_words(14'h0100, 16);
    @(posedge clk); #1;

    // Back-pressure: consumer stalled for 40 cycles
    clear_capture();
    src_ready = 1'b0;
    send_cmd(14'h0200, 14'd32);
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("t3_reads_at_credit", 32'(acc_total), 32'd8);
    chk("t3_inflight_peak", 32'(max_inflight), 32'd8);
    chk("t3_no_pops", 32'(pop_total), 32'd0);
    chk("t3_src_valid", 32'(src_valid), 32'h1);
    src_ready = 1'b1;
    wait_done(600, dcyc);
    check_words(14'h0200, 32);
    chk("t3_inflight_bound", 32'(max_inflight), 32'd8);
    @(posedge clk); #1;

    // Address wrap
    clear_capture();
    send_cmd(14'h3FFE, 14'd4);
    wait_done(200, dcyc);
    chk("t4_words", 32'(got_data.size()), 32'd4);
    if (acc_addrs.size() == 4) begin
      chk("t4_addr0", 32'(acc_addrs[0]), 32'h3FFE);
      chk("t4_addr1", 32'(acc_addrs[1]), 32'h3FFF);
      chk("t4_addr2", 32'(acc_addrs[2]), 32'h0000);
      chk("t4_addr3", 32'(acc_addrs[3]), 32'h0001);
    end else begin
      chk("t4_addr_count", 32'(acc_addrs.size()), 32'd4);
    end
    if (got_data.size() == 4) begin
      chk("t4_data2", got_data[2], 32'hC0DE0000);
      chk("t4_last3", 32'(got_last[3]), 32'h1);
    end
    @(posedge clk); #1;

    // No-op command, then spurious readdatavalid
    clear_capture();
    acc0 = acc_total;
    send_cmd(14'h0123, 14'd0);
    chk("t5_done_cycle1", 32'(done), 32'h1);
    chk("t5_no_read", 32'(avm.read), 32'h0);
    @(posedge clk); #1;
    chk("t5_done_cleared", 32'(done), 32'h0);
    chk("t5_reads", 32'(acc_total - acc0), 32'd0);
    @(posedge clk); #1;
    chk("t5_idle_ready", 32'(cmd_ready), 32'h1);
    inject_rdv = 1'b1;
    @(posedge clk); #1;
    inject_rdv = 1'b0;
    chk("t5_err_set", 32'(err), 32'h1);
    chk("t5_dropped", 32'(src_valid), 32'h0);
    @(posedge clk); #1;
    chk("t5_err_sticky", 32'(err), 32'h1);
    clear_capture();
    send_cmd(14'h0005, 14'd1);
    chk("t5_err_cleared", 32'(err), 32'h0);
    wait_done(100, dcyc);
    check_words(14'h0005, 1);
    @(posedge clk); #1;

    // Reset mid-ISSUE, then a fresh command
    clear_capture();
    send_cmd(14'h0040, 14'd16);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t6_busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_capture();
    send_cmd(14'h0010, 14'd4);
    wait_done(100, dcyc);
    check_words(14'h0010, 4);
    chk("t6_err_after", 32'(err), 32'h0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/avm_rom_reader.md
# avm_rom_reader

Avalon-MM read master that fetches a block of consecutive 32-bit words from an on-chip memory slave (the Qsys program/data ROM) and delivers them in order on a valid/ready stream. It accepts one command (start word address, word count), issues pipelined reads honouring `waitrequest`/`readdatavalid`, and buffers returned data in a small FIFO. Credit-based issue guarantees returned data is never dropped. It sits between the Qsys interconnect and LED-pattern / datapath consumers.

## Interface
- `ADDR_W`, 14, word-address width; matches the 10240-word ROM
- `DATA_W`, 32, data width
- `LEN_W`, 14, word-count width
- `FIFO_DEPTH`, 8, return-buffer depth (power of 2, ≥2); also the maximum number of reads in flight
- `clk`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_addr`  in  ADDR_W  start word address
- `cmd_len`  in  LEN_W  number of words; 0 = no-op
- `avm_address`  out  ADDR_W  word address
- `avm_read`  out  1  read request
- `avm_byteenable`  out  4  constant 4'hF
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  DATA_W  return data
- `avm_readdatavalid`  in  1  return-data strobe
- `src_data`  out  DATA_W  stream data
- `src_valid`  out  1  stream valid
- `src_ready`  in  1  consumer ready
- `src_last`  out  1  marks final word of the command
- `busy`  out  1  high in all states except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky: `readdatavalid` arrived with no read outstanding; cleared on the next command acceptance

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: command accepted on `cmd_valid && cmd_ready`; latch address and length; clear `err`. If `cmd_len`==0, go to DONE; otherwise go to ISSUE.
- ISSUE: raise `avm_read` only when `outstanding + fifo_count < FIFO_DEPTH`. Once raised, `avm_read` and `avm_address` hold stable until `!avm_waitrequest`, regardless of credit.
- On read acceptance: increment address (wraps modulo 2^ADDR_W), decrement remaining, increment `outstanding`. After the last read is accepted, go to DRAIN.
- `avm_readdatavalid`: push `avm_readdata` into the FIFO and decrement `outstanding`. Accept and return on the same cycle leaves `outstanding` unchanged.
- `avm_readdatavalid` with `outstanding`==0 (and no acceptance that cycle): data is dropped and `err` is set.
- Stream output: `src_valid` = FIFO not empty. Pop on `src_valid && src_ready`. Pop counter compares against the latched length to drive `src_last`.
- DRAIN: when the last word is popped, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Simultaneous FIFO push and pop: count unchanged. Push at full cannot occur by the credit rule; assert in simulation.
- Reset mid-operation clears all state. In-flight reads are abandoned; the fabric is reset together with this block.

## Timing
- Reset values: `cmd_ready`=1, `avm_read`=0, `avm_address`=0, `src_valid`=0, `src_last`=0, `src_data`=0, `busy`=0, `done`=0, `err`=0.
- Command accepted in cycle 0 → `avm_read` high in cycle 1.
- With zero wait states and `src_ready`=1, one read is issued per cycle sustained.
- `readdatavalid` in cycle N → `src_valid` in cycle N+1 (registered FIFO, show-ahead).
- Final pop in cycle M → `done` in cycle M+1 → `cmd_ready` in cycle M+2.
- No-op command accepted in cycle 0 → `done` in cycle 1.
- All outputs are registered except `src_valid`, `src_data`, and `src_last`, which are driven from FIFO registers.

## Structure
- Package `avm_rom_reader_pkg`:
  - state enum `rdr_state_t`
  - constant `AVM_BE_ALL` = 4'hF
  - default width constants
- Sub-module `avm_reader_fifo`: synchronous show-ahead FIFO, parameters DATA_W/FIFO_DEPTH. It exposes `count` for the credit check. Async active-low reset.
- Top level holds the FSM, address/length/outstanding counters, and the `src_last` compare.

## Test plan
- Zero-wait slave with 1-cycle return latency, addr 0x0000, len 16, `src_ready`=1 → 16 words in address order, `src_last` on word 16, `done` one cycle after the final pop, `avm_read` high for 16 consecutive cycles.
- Random `waitrequest` (50%) → `avm_address` and `avm_read` never change while stalled; 16 correct words delivered.
- `src_ready`=0 for 40 cycles, len 32 → `outstanding + fifo_count` never exceeds 8; no lost data after `src_ready` rises.
- addr 0x3FFE, len 4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- len 0 → no `avm_read`; `done` in cycle 1; spurious `readdatavalid` in IDLE sets `err`; next command acceptance clears it.
- `reset_n` pulsed low mid-ISSUE → all outputs at reset values immediately; a new command afterwards completes normally.
